// File: rtl/tick_if.sv
// Command and status bundle between the front panel and tick_sequencer.
// Commands flow in from the master, and tick/count/status flow back.
interface tick_if;
  logic       start;
  logic       stop;
  logic       step;
  logic       clear;
  logic [1:0] rate_sel;
  logic       wrap;
  logic       tick;
  logic [3:0] count;
  logic       running;
  logic       done;

  modport master (
    output start, stop, step, clear,
    output rate_sel, wrap,
    input  tick, count, running, done
  );

  modport slave (
    input  start, stop, step, clear,
    input  rate_sel, wrap,
    output tick, count, running, done
  );
endinterface

// File: rtl/tick_sequencer.sv
// Run/pause/step controller with a programmable rate divider.
// It drives a 4-bit display count and a one-cycle tick pulse.
module tick_sequencer #(
  parameter int DIV_W    = 27,
  parameter int RATE0    = 0,
  parameter int RATE1    = 24999999,
  parameter int RATE2    = 49999999,
  parameter int RATE3    = 99999999,
  parameter int TERMINAL = 15
) (
  input logic   clock,
  input logic   reset,
  tick_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    DONE
  } state_t;

  localparam logic [3:0] TERM = 4'(TERMINAL);

  state_t           state, state_n;
  logic [DIV_W-1:0] div, div_n;
  logic [DIV_W-1:0] rate, rate_n;
  logic [DIV_W-1:0] sel_rate;
  logic [3:0]       cnt, cnt_n, cnt_inc;
  logic             tick, tick_n;
  logic             hit;

  always_comb begin
    unique case (bus.rate_sel)
      2'd0:    sel_rate = DIV_W'(RATE0);
      2'd1:    sel_rate = DIV_W'(RATE1);
      2'd2:    sel_rate = DIV_W'(RATE2);
      default: sel_rate = DIV_W'(RATE3);
    endcase
  end

  assign cnt_inc = cnt + 4'd1;
  assign hit     = !bus.wrap && (cnt_inc == TERM);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      div   <= '0;
      rate  <= DIV_W'(RATE0);
      cnt   <= '0;
      tick  <= 1'b0;
    end else begin
      state <= state_n;
      div   <= div_n;
      rate  <= rate_n;
      cnt   <= cnt_n;
      tick  <= tick_n;
    end
  end

  // stop outranks start/step in every state, even where it has no effect
  always_comb begin
    state_n = state;
    div_n   = div;
    rate_n  = rate;
    cnt_n   = cnt;
    tick_n  = 1'b0;
    if (bus.clear) begin
      state_n = IDLE;
      div_n   = '0;
      cnt_n   = '0;
    end else if (bus.stop) begin
      if (state == RUN)
        state_n = PAUSE;
    end else begin
      unique case (state)
        IDLE, PAUSE: begin
          if (bus.start) begin
            state_n = RUN;
            if (state == IDLE) begin
              rate_n = sel_rate;
              div_n  = '0;
            end
          end else if (bus.step) begin
            cnt_n  = cnt_inc;
            tick_n = 1'b1;
            if (hit)
              state_n = DONE;
          end
        end
        RUN: begin
          if (div == rate) begin
            div_n  = '0;
            rate_n = sel_rate;
            cnt_n  = cnt_inc;
            tick_n = 1'b1;
            if (hit)
              state_n = DONE;
          end else begin
            div_n = div + 1'b1;
          end
        end
        DONE: begin
          if (bus.start) begin
            state_n = RUN;
            cnt_n   = '0;
            div_n   = '0;
            rate_n  = sel_rate;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  assign bus.tick    = tick;
  assign bus.count   = cnt;
  assign bus.running = (state == RUN);
  assign bus.done    = (state == DONE);

endmodule

// File: tb/tb_tick_sequencer.sv
// Directed and random checks of tick_sequencer against a
// period-counting reference model.
module tb_tick_sequencer;

  localparam int TERM = 5;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mode_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  tick_if bus ();

  tick_sequencer #(
    .DIV_W   (8),
    .RATE0   (0),
    .RATE1   (2),
    .RATE2   (4),
    .RATE3   (9),
    .TERMINAL(TERM)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clock = ~clock;

  int    rates [4] = '{0, 2, 4, 9};
  int    n_cmp = 0;
  int    n_bad = 0;
  logic [1:0] rs = 2'd0;
  bit    wr = 1'b0;

  mode_t m_mode;
  int    m_count;
  int    m_elapsed;
  int    m_period;
  bit    m_tick;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h",
             tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode    = M_IDLE;
    m_count   = 0;
    m_elapsed = 0;
    m_period  = rates[0] + 1;
    m_tick    = 1'b0;
  endtask

  task automatic bump(input bit w);
    m_count = (m_count + 1) % 16;
    m_tick  = 1'b1;
    if (!w && m_count == TERM)
      m_mode = M_DONE;
  endtask

  task automatic model_edge(input bit st, input bit sp,
                            input bit sg, input bit cl,
                            input logic [1:0] r,
                            input bit w);
    m_tick = 1'b0;
    if (cl) begin
      m_count   = 0;
      m_elapsed = 0;
      m_mode    = M_IDLE;
    end else if (sp) begin
      if (m_mode == M_RUN)
        m_mode = M_PAUSE;
    end else if (st && m_mode != M_RUN) begin
      if (m_mode != M_PAUSE) begin
        m_period  = rates[r] + 1;
        m_elapsed = 0;
      end
      if (m_mode == M_DONE)
        m_count = 0;
      m_mode = M_RUN;
    end else if (m_mode == M_RUN) begin
      m_elapsed++;
      if (m_elapsed == m_period) begin
        m_elapsed = 0;
        m_period  = rates[r] + 1;
        bump(w);
      end
    end else if (sg && m_mode != M_DONE) begin
      bump(w);
    end
  endtask

  task automatic cyc(input bit st = 0, input bit sp = 0,
                     input bit sg = 0, input bit cl = 0);
    bus.start    = st;
    bus.stop     = sp;
    bus.step     = sg;
    bus.clear    = cl;
    bus.rate_sel = rs;
    bus.wrap     = wr;
    @(posedge clock);
    model_edge(st, sp, sg, cl, rs, wr);
    #1;
    check("tick", 32'(bus.tick), 32'(m_tick));
    check("count", 32'(bus.count), m_count);
    check("running", 32'(bus.running),
          32'(m_mode == M_RUN));
    check("done", 32'(bus.done),
          32'(m_mode == M_DONE));
    bus.start = 1'b0;
    bus.stop  = 1'b0;
    bus.step  = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic wait_tick(input string tag,
                           input int exp);
    int n;
    n = 0;
    do begin
      cyc();
      n++;
    end while (!bus.tick && n < 40);
    check(tag, n, exp);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.stop     = 1'b0;
    bus.step     = 1'b0;
    bus.clear    = 1'b0;
    bus.rate_sel = 2'd0;
    bus.wrap     = 1'b0;
    model_reset();
    #12;
    check("rst_tick", 32'(bus.tick), 0);
    check("rst_count", 32'(bus.count), 0);
    check("rst_running", 32'(bus.running), 0);
    check("rst_done", 32'(bus.done), 0);
    reset = 1'b1;

    // 1: rate 2, wrap, ticks every 3 cycles
    rs = 2'd1;
    wr = 1'b1;
    cyc(.st(1));
    wait_tick("s1_first", 3);
    wait_tick("s1_second", 3);
    check("s1_count2", 32'(bus.count), 2);
    repeat (42) cyc();
    check("s1_wrap", 32'(bus.count), 0);
    check("s1_run", 32'(bus.running), 1);

    // 2: pause at divider 4, resume
    cyc(.cl(1));
    rs = 2'd3;
    cyc(.st(1));
    repeat (4) cyc();
    cyc(.sp(1));
    check("s2_paused", 32'(bus.running), 0);
    repeat (20) cyc();
    cyc(.st(1));
    wait_tick("s2_resume", 6);
    check("s2_count", 32'(bus.count), 1);

    // 3: rate change mid-period
    cyc(.cl(1));
    rs = 2'd1;
    cyc(.st(1));
    rs = 2'd3;
    wait_tick("s3_old_rate", 3);
    wait_tick("s3_new_rate", 10);

    // 4: one-shot to terminal
    cyc(.cl(1));
    wr = 1'b0;
    rs = 2'd0;
    cyc(.st(1));
    repeat (5) cyc();
    check("s4_count", 32'(bus.count), TERM);
    check("s4_done", 32'(bus.done), 1);
    check("s4_running", 32'(bus.running), 0);
    cyc(.sg(1));
    check("s4_step_ign", 32'(bus.tick), 0);
    cyc(.st(1));
    check("s4_restart", 32'(bus.count), 0);
    check("s4_rerun", 32'(bus.running), 1);

    // 5: single steps from IDLE; stop beats step
    cyc(.cl(1));
    wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc(.sg(1));
      cyc();
      cyc();
    end
    check("s5_count", 32'(bus.count), 3);
    check("s5_idle", 32'(bus.running), 0);
    rs = 2'd3;
    cyc(.st(1));
    cyc(.sp(1));
    cyc(.sp(1), .sg(1));
    check("s5_no_tick", 32'(bus.tick), 0);
    check("s5_hold", 32'(bus.count), 3);

    // 6: clear beats start; async reset
    cyc(.cl(1));
    rs = 2'd0;
    cyc(.st(1));
    repeat (7) cyc();
    check("s6_count7", 32'(bus.count), 7);
    cyc(.st(1), .cl(1));
    check("s6_clr_cnt", 32'(bus.count), 0);
    check("s6_clr_run", 32'(bus.running), 0);
    check("s6_clr_tick", 32'(bus.tick), 0);
    rs = 2'd2;
    cyc(.st(1));
    repeat (5) cyc();
    check("s6_pre_tick", 32'(bus.tick), 1);
    #1 reset = 1'b0;
    #1;
    check("s6_ar_tick", 32'(bus.tick), 0);
    check("s6_ar_count", 32'(bus.count), 0);
    check("s6_ar_run", 32'(bus.running), 0);
    check("s6_ar_done", 32'(bus.done), 0);
    reset = 1'b1;
    model_reset();

    // random commands against the model
    for (int i = 0; i < 400; i++) begin
      int r;
      r = $urandom_range(0, 19);
      if ($urandom_range(0, 29) == 0)
        rs = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0)
        wr = ~wr;
      unique case (r)
        0:       cyc(.st(1));
        1:       cyc(.sp(1));
        2, 3:    cyc(.sg(1));
        4:       cyc(.cl(1));
        default: cyc();
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
